// File: rtl/ms_reaction_counter.sv
// Millisecond stopwatch: divides clk into a 1 ms tick and keeps matching packed-BCD and
// binary counts that saturate at MAX_MS, with a synchronous clear from the game controller.
module ms_reaction_counter #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned MAX_MS   = 99999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clreset,
    output logic [19:0] count,
    output logic [19:0] count_binary,
    output logic        ms_tick,
    output logic        saturated
);

    localparam int unsigned PscW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PscW-1:0] PscLast = PscW'(TICK_DIV - 1);
    localparam logic [19:0] MaxMs = 20'(MAX_MS);

    logic [PscW-1:0] psc_q;
    logic [19:0]     count_q;
    logic [19:0]     bin_q;
    logic            tick_q;
    logic            sat_q;

    logic [19:0]     bcd_inc;
    logic            at_max;
    logic            psc_wrap;

    assign psc_wrap = (psc_q == PscLast);
    assign at_max   = (bin_q == MaxMs);

    // Ripple the +1 through the digits: a 9 rolls to 0 and passes the carry upward.
    always_comb begin
        logic carry;
        bcd_inc = count_q;
        carry   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q   <= '0;
            count_q <= '0;
            bin_q   <= '0;
            tick_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else if (clreset) begin
            psc_q   <= '0;
            count_q <= '0;
            bin_q   <= '0;
            tick_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else if (psc_wrap) begin
            psc_q <= '0;
            if (at_max) begin
                tick_q <= 1'b0;
                sat_q  <= 1'b1;
            end else begin
                count_q <= bcd_inc;
                bin_q   <= bin_q + 20'd1;
                tick_q  <= 1'b1;
            end
        end else begin
            psc_q  <= psc_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign count        = count_q;
    assign count_binary = bin_q;
    assign ms_tick      = tick_q;
    assign saturated    = sat_q;

endmodule

// File: tb/tb_ms_reaction_counter.sv
// Bench for ms_reaction_counter: vector table, hand-written corner sequences and a random
// clear pattern checked against an integer millisecond model.
module tb_ms_reaction_counter;

    logic        clk;
    logic        rst_n;
    logic        clr_a, clr_b, clr_c;
    logic [19:0] cnt_a, bin_a, cnt_b, bin_b, cnt_c, bin_c;
    logic        tick_a, sat_a, tick_b, sat_b, tick_c, sat_c;

    int total  = 0;
    int passed = 0;

    ms_reaction_counter #(.TICK_DIV(4), .MAX_MS(99999)) u_a (
        .clk(clk), .rst_n(rst_n), .clreset(clr_a), .count(cnt_a), .count_binary(bin_a),
        .ms_tick(tick_a), .saturated(sat_a)
    );
    ms_reaction_counter #(.TICK_DIV(2), .MAX_MS(99999)) u_b (
        .clk(clk), .rst_n(rst_n), .clreset(clr_b), .count(cnt_b), .count_binary(bin_b),
        .ms_tick(tick_b), .saturated(sat_b)
    );
    ms_reaction_counter #(.TICK_DIV(4), .MAX_MS(12)) u_c (
        .clk(clk), .rst_n(rst_n), .clreset(clr_c), .count(cnt_c), .count_binary(bin_c),
        .ms_tick(tick_c), .saturated(sat_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [19:0] bcd;
        logic [19:0] bin;
        logic        tick;
        logic        sat;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          d;
        r = '0;
        d = 1;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((v / d) % 10);
            d = d * 10;
        end
        return r;
    endfunction

    // Reference model state: integer milliseconds plus a cycle phase within the tick.
    int m_ms, m_phase, m_ticks;
    logic m_tick, m_sat;

    initial begin
        bit nib_bad;
        int n;

        // Vectors start from a fresh reset (prescaler 0); first edge clears.
        tbl[0]  = '{1'b1, 20'h00000, 20'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 20'h00000, 20'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 20'h00000, 20'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 20'h00000, 20'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 20'h00001, 20'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 20'h00001, 20'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 20'h00001, 20'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 20'h00001, 20'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 20'h00002, 20'd2, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 20'h00002, 20'd2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 20'h00002, 20'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 20'h00002, 20'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 20'h00003, 20'd3, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 20'h00003, 20'd3, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 20'h00003, 20'd3, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 20'h00003, 20'd3, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 20'h00000, 20'd0, 1'b0, 1'b0};  // clear lands on prescaler==3
        tbl[17] = '{1'b0, 20'h00000, 20'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b1;
        clr_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", cnt_a, 20'h0);
        chk("reset_bin", bin_a, 20'd0);
        chk("reset_tick", {19'd0, tick_a}, 20'd0);
        chk("reset_sat", {19'd0, sat_a}, 20'd0);
        rst_n = 1'b1;

        // Async reset mid-count at 37 ms.
        n = 0;
        while (bin_a != 20'd37 && n < 400) begin
            step();
            n++;
        end
        chk("reach_37", bin_a, 20'd37);
        chk("bcd_37", cnt_a, 20'h00037);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_count", cnt_a, 20'h0);
        chk("async_rst_bin", bin_a, 20'd0);
        chk("async_rst_tick", {19'd0, tick_a}, 20'd0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            clr_a = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_count", i), cnt_a, tbl[i].bcd);
            chk($sformatf("vec%0d_bin", i), bin_a, tbl[i].bin);
            chk($sformatf("vec%0d_tick", i), {19'd0, tick_a}, {19'd0, tbl[i].tick});
            chk($sformatf("vec%0d_sat", i), {19'd0, sat_a}, {19'd0, tbl[i].sat});
        end

        // BCD carry across digits (TICK_DIV=2 instance).
        clr_b = 1'b0;
        n = 0;
        while (bin_b != 20'd9 && n < 100) begin step(); n++; end
        chk("b_reach_9", bin_b, 20'd9);
        n = 0;
        while (bin_b == 20'd9 && n < 5) begin step(); n++; end
        chk("carry_10_bcd", cnt_b, 20'h00010);
        chk("carry_10_bin", bin_b, 20'd10);
        n = 0;
        while (bin_b != 20'd9999 && n < 25000) begin step(); n++; end
        chk("b_reach_9999", bin_b, 20'd9999);
        chk("bcd_9999", cnt_b, 20'h09999);
        n = 0;
        while (bin_b == 20'd9999 && n < 5) begin step(); n++; end
        chk("carry_10000_bcd", cnt_b, 20'h10000);
        chk("carry_10000_bin", bin_b, 20'd10000);
        chk("carry_10000_tick", {19'd0, tick_b}, 20'd1);
        clr_b = 1'b1;

        // Saturation at MAX_MS=12, then clear and resume.
        clr_c = 1'b0;
        n = 0;
        while (bin_c != 20'd12 && n < 200) begin step(); n++; end
        chk("c_reach_12", bin_c, 20'd12);
        n = 0;
        for (int i = 0; i < 84; i++) begin
            step();
            if (tick_c || bin_c != 20'd12) n++;
        end
        chk("sat_no_tick_no_change", 20'(n), 20'd0);
        chk("sat_count", cnt_c, 20'h00012);
        chk("sat_flag", {19'd0, sat_c}, 20'd1);
        clr_c = 1'b1;
        step();
        chk("sat_clr_bin", bin_c, 20'd0);
        chk("sat_clr_count", cnt_c, 20'h0);
        chk("sat_clr_flag", {19'd0, sat_c}, 20'd0);
        clr_c = 1'b0;
        repeat (4) step();
        chk("resume_bin", bin_c, 20'd1);
        chk("resume_tick", {19'd0, tick_c}, 20'd1);

        // Random clear pattern on instance A against the millisecond model.
        m_ms = 0; m_phase = 0; m_ticks = 0; m_tick = 1'b0; m_sat = 1'b0;
        n = 0;
        clr_a = 1'b1;
        while (m_ticks < 5000 && n < 40000) begin
            if (n == 0) clr_a = 1'b1;
            else if (n >= 100 && n < 140) clr_a = n[0];
            else clr_a = ($urandom_range(0, 499) == 0);
            if (clr_a) begin
                m_ms = 0; m_phase = 0; m_tick = 1'b0; m_sat = 1'b0;
            end else if (m_phase == 3) begin
                m_phase = 0;
                if (m_ms == 99999) begin
                    m_tick = 1'b0;
                    m_sat  = 1'b1;
                end else begin
                    m_ms++;
                    m_ticks++;
                    m_tick = 1'b1;
                end
            end else begin
                m_phase++;
                m_tick = 1'b0;
            end
            step();
            n++;
            chk("rnd_bin", bin_a, 20'(m_ms));
            chk("rnd_count", cnt_a, to_bcd(m_ms));
            chk("rnd_tick", {19'd0, tick_a}, {19'd0, m_tick});
            chk("rnd_sat", {19'd0, sat_a}, {19'd0, m_sat});
            nib_bad = 1'b0;
            for (int k = 0; k < 5; k++) if (cnt_a[4*k +: 4] > 4'd9) nib_bad = 1'b1;
            chk("rnd_nibble_range", {19'd0, nib_bad}, 20'd0);
        end
        chk("rnd_tick_budget", {19'd0, (m_ticks >= 5000)}, 20'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
